// File: rtl/bitstream_byte_packer.sv
// Packs 0-8 MSB-aligned bytes per cycle into 64-bit words behind a first-word-fall-through FIFO.
// Optional feature: define BYTE_PACKER_STALL_COUNT_EN to add the stall_count output.
module bitstream_byte_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  in_byte_count,
    input  logic [63:0] in_val,
    input  logic        flush,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [7:0]  out_byte_en,
    output logic        overflow,
    output logic        busy,
    output logic [31:0] total_word_count
`ifdef BYTE_PACKER_STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 73;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t             state_r, state_nx;
    logic [119:0]       acc_r, acc_nx;
    logic [2:0]         res_r, res_nx;
    logic [3:0]         n_s;
    logic [3:0]         sum_s;
    logic [63:0]        in_mask_s;
    logic [119:0]       merged_s;
    logic               push_s;
    logic [63:0]        push_data_s;
    logic               push_last_s;
    logic [7:0]         push_be_s;
    logic               in_drop_s;

    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   scount_r, occ_s;
    logic               full_s, pop_s, can_push_s, load_s, wr_en_s;
    logic [63:0]        out_data_r;
    logic               out_valid_r, out_last_r;
    logic [7:0]         out_be_r;
    logic               overflow_r, busy_r;
    logic [31:0]        word_cnt_r;

    // FIFO occupancy; the output register counts as one of the FIFO_DEPTH entries
    always_comb begin
        occ_s      = scount_r + CNT_W'(out_valid_r);
        full_s     = (occ_s == CNT_W'(FIFO_DEPTH));
        pop_s      = out_valid_r & out_ready;
        can_push_s = ~full_s | pop_s;
        load_s     = (~out_valid_r | pop_s) & (scount_r != {CNT_W{1'b0}});
    end

    // Accumulator append, full-word extraction and RUN/FLUSH next-state logic
    always_comb begin
        n_s         = (in_byte_count > 4'd8) ? 4'd8 : in_byte_count;
        in_mask_s   = ~(64'hFFFF_FFFF_FFFF_FFFF >> {n_s, 3'b000});
        merged_s    = acc_r | ({in_val & in_mask_s, 56'd0} >> {res_r, 3'b000});
        sum_s       = {1'b0, res_r} + n_s;
        state_nx    = state_r;
        acc_nx      = acc_r;
        res_nx      = res_r;
        push_s      = 1'b0;
        push_data_s = 64'd0;
        push_last_s = 1'b0;
        push_be_s   = 8'd0;
        in_drop_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (sum_s >= 4'd8) begin
                    push_s      = 1'b1;
                    push_data_s = merged_s[119:56];
                    push_be_s   = 8'hFF;
                    acc_nx      = {merged_s[55:0], 64'd0};
                end else begin
                    acc_nx      = merged_s;
                end
                // sum - 8 and sum share the low three bits over the reachable range
                res_nx = sum_s[2:0];
                if (flush) begin
                    state_nx = ST_FLUSH;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if ((in_byte_count != 4'd0) || flush) begin
                    in_drop_s = 1'b1;
                end else begin
                    in_drop_s = 1'b0;
                end
                if (can_push_s) begin
                    push_s      = 1'b1;
                    push_data_s = acc_r[119:56];
                    push_last_s = 1'b1;
                    push_be_s   = ~(8'hFF >> res_r);
                    acc_nx      = 120'd0;
                    res_nx      = 3'd0;
                    state_nx    = ST_RUN;
                end else begin
                    state_nx    = ST_FLUSH;
                end
            end
            default: begin
                state_nx = ST_RUN;
                acc_nx   = 120'd0;
                res_nx   = 3'd0;
            end
        endcase
        wr_en_s = push_s & can_push_s;
    end

    // Packer state registers
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_r <= ST_RUN;
            acc_r   <= 120'd0;
            res_r   <= 3'd0;
        end else begin
            state_r <= state_nx;
            acc_r   <= acc_nx;
            res_r   <= res_nx;
        end
    end

    // FIFO storage, pointers and registered head
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            scount_r    <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= 64'd0;
            out_last_r  <= 1'b0;
            out_be_r    <= 8'd0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= {push_data_s, push_last_s, push_be_s};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mem_r[rd_ptr_r][72:9];
                out_last_r  <= mem_r[rd_ptr_r][8];
                out_be_r    <= mem_r[rd_ptr_r][7:0];
                rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
                out_data_r  <= 64'd0;
                out_last_r  <= 1'b0;
                out_be_r    <= 8'd0;
            end
            case ({wr_en_s, load_s})
                2'b10:   scount_r <= scount_r + CNT_W'(1);
                2'b01:   scount_r <= scount_r - CNT_W'(1);
                default: scount_r <= scount_r;
            endcase
        end
    end

    // Status flags and counters
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            word_cnt_r <= 32'd0;
        end else begin
            if (in_drop_s || (push_s && !can_push_s)) begin
                overflow_r <= 1'b1;
            end
            busy_r <= (state_r != ST_RUN) || (res_r != 3'd0) || (occ_s != {CNT_W{1'b0}});
            if (pop_s) begin
                word_cnt_r <= word_cnt_r + 32'd1;
            end
        end
    end

`ifdef BYTE_PACKER_STALL_COUNT_EN
    logic [31:0] stall_cnt_r;

    // Cycles where the head word waits on the sink
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            stall_cnt_r <= 32'd0;
        end else if (out_valid_r && !out_ready) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_count = stall_cnt_r;
`endif

    assign out_data         = out_data_r;
    assign out_valid        = out_valid_r;
    assign out_last         = out_last_r;
    assign out_byte_en      = out_be_r;
    assign overflow         = overflow_r;
    assign busy             = busy_r;
    assign total_word_count = word_cnt_r;

endmodule

// File: doc/bitstream_byte_packer.md
# bitstream_byte_packer

Downstream stage of the bit packer in the ProRes bitstream path. Each cycle it takes 0–8 MSB-aligned bytes and packs them into contiguous 64-bit words. Packed words pass through a small first-word-fall-through FIFO to a valid/ready sink, such as a memory writer or DMA. A flush request terminates the slice with a final partial word that carries a byte-enable mask.

## Interface
- FIFO_DEPTH, 4, number of 64-bit word entries in the output FIFO; must be a power of two, minimum 2.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-high.
- in_byte_count  in  4  number of valid bytes in in_val this cycle; 0 = no data; values 9–15 are treated as 8.
- in_val  in  64  byte stream, first byte at [63:56]; bytes below the count are ignored.
- flush  in  1  end of slice; sampled together with the same cycle's bytes.
- out_data  out  64  packed word, first byte at [63:56]; unused bytes are zero.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  sink accepts the word when out_valid && out_ready.
- out_last  out  1  head word is the terminating word of a flush.
- out_byte_en  out  8  valid-byte mask of the head word, top-aligned; 8'hFF for full words.
- overflow  out  1  sticky; a word or input was dropped.
- busy  out  1  state != RUN, or residual bytes != 0, or FIFO not empty.
- total_word_count  out  32  number of words handed to the sink; wraps modulo 2^32.
- stall_count  out  32  present only with BYTE_PACKER_STALL_COUNT_EN.

## Operation
- **Accumulator:** 120-bit register plus a residual count `res` of 0–7 bytes.
  - Each RUN cycle appends the top n = min(in_byte_count, 8) bytes of in_val immediately after the residual.
- **Full word:** if res + n >= 8, the first 8 bytes are pushed to the FIFO with byte_en 8'hFF and last 0. The remaining res + n − 8 bytes shift to the top, and `res` is updated. At most one full word is produced per cycle.
- **FSM states:** RUN and FLUSH.
  - RUN with flush = 1: the cycle's bytes are applied first, then the FSM goes to FLUSH.
  - FLUSH: when the FIFO is not full, it pushes the residual as one word. Data is zero-padded, last = 1, and byte_en is a top-aligned mask of `res` bits (e.g. res = 3 gives 8'hE0; res = 0 gives 8'h00 with last = 1). It then clears `res` and returns to RUN.
  - FLUSH while the FIFO is full: the FSM holds in FLUSH until the FIFO has space.
- **Input during FLUSH:** in_byte_count != 0 or flush = 1 is dropped and sets overflow.
- **FIFO full on a full-word push in RUN:** the word is dropped, overflow is set, and the accumulator still advances. Loss is flagged, never stalled, because the upstream stage has no backpressure.
- **FIFO:** first-word-fall-through.
  - A push and a pop in the same cycle on a full FIFO is legal and is not an overflow.
  - A push and a pop in the same cycle on an empty FIFO: the pushed word becomes the head on the next cycle.
- **total_word_count** increments on every out_valid && out_ready handshake.
- **overflow** is cleared only by reset.

## Timing
- **Reset** (asynchronous):
  - FSM = RUN, res = 0, FIFO empty.
  - out_valid = 0, out_data = 0, out_last = 0, out_byte_en = 0.
  - overflow = 0, busy = 0, total_word_count = 0, stall_count = 0.
  - Reset mid-slice discards the residual and all FIFO contents with no output.
- **Latency:**
  - The byte completing a word at edge t appears on out_data with out_valid = 1 after edge t+1.
  - A flush sampled at edge t, with FIFO space, gives the last word valid after edge t+2.
- **Handshake:** while out_valid && !out_ready, out_data, out_last and out_byte_en are held stable.
- **Sustained throughput:** 8 bytes per cycle in and 1 word per cycle out with out_ready held at 1. No bubbles.
- **busy** is registered and falls on the edge after the last word is popped.

## Configuration
- BYTE_PACKER_STALL_COUNT_EN:
  - Defined: a 32-bit stall_count port exists. It increments each cycle that out_valid && !out_ready, wraps, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert reset_n with bytes pending → all outputs 0 next cycle, no words emitted after release.
- **Single bytes:** eight single-byte inputs 0x11..0x88 → one word 0x1122334455667788, byte_en 8'hFF, last 0, valid one cycle after the 8th byte; total_word_count = 1.
- **Five plus five, then flush:** 5 bytes AA..EE, then 5 bytes 01..05 → word 0xAABBCCDDEE010203. Flush → word 0x0405000000000000, byte_en 8'hC0, last 1.
- **Full word with flush:** 3 bytes, then 8 bytes with flush = 1 → full word, then the last word with byte_en 8'hE0 on the following cycle. Input during the FLUSH cycle sets overflow.
- **Backpressure:** out_ready = 0, push FIFO_DEPTH + 1 full words → overflow = 1. The first FIFO_DEPTH words drain intact and in order when out_ready = 1. With the macro defined, stall_count equals the cycles spent valid && !ready.
- **Streaming:** 100 cycles of 8 bytes with random out_ready (never full) → output matches the input byte sequence exactly, no overflow.
